id_hazard_ctrl: RTL

- Parametrised forwarding and interlock controller for the decode stage.
- Tracks in-flight register writes across DEPTH post-decode stages in a shift-register scoreboard.
- Selects the youngest forwardable result for each of two source operands.
- Raises a load-use stall when the producing load has not yet reached the stage where its data is available. Sits between register file read and the ID/EX pipeline register.

---
 rtl/id_hazard_ctrl_pkg.sv | 36 +++
 rtl/id_fwd_select.sv | 40 ++++
 rtl/id_hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the decode-stage forwarding/interlock controller:
// register address type, scoreboard entry, write-enable and scheduling codes.
package id_hazard_ctrl_pkg;

  localparam int REG_AW = 4;

  typedef logic [REG_AW-1:0] REG_T;

  localparam REG_T REG_INVALID = 4'hF;

  // Destination write classification of the decode instruction
  typedef enum logic [1:0] {
    RWE_NONE = 2'b00,
    RWE_ALU  = 2'b10,
    RWE_LOAD = 2'b11
  } rwe_e;

  typedef struct packed {
    logic valid;
    REG_T dst;
    logic is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SCHED_IDLE         = 2'b00,
    SCHED_ISSUE        = 2'b01,
    SCHED_PAUSE_FOR_LW = 2'b10,
    SCHED_KILL         = 2'b11
  } sched_e;

  function automatic rwe_e rwe_decode(input logic we, input logic is_load);
    if (!we) return RWE_NONE;
    return is_load ? RWE_LOAD : RWE_ALU;
  endfunction

endpackage

// File: rtl/id_fwd_select.sv
// Per-source operand resolution: youngest matching scoreboard entry wins;
// a load that has not reached its data-ready stage is reported as a hazard.
module id_fwd_select
  import id_hazard_ctrl_pkg::*;
#(
  parameter int   DATA_W     = 16,
  parameter int   DEPTH      = 3,
  parameter int   LOAD_READY = 1,
  parameter REG_T SRC_NONE   = id_hazard_ctrl_pkg::REG_INVALID
) (
  input  REG_T                     i_src,
  input  sb_entry_t [DEPTH-1:0]    i_sb,
  input  logic [DEPTH*DATA_W-1:0]  i_stage_result,
  input  logic [DATA_W-1:0]        i_reg_data,
  output logic [DATA_W-1:0]        o_op,
  output logic                     o_hit,
  output logic                     o_hazard
);

  // Walk oldest to youngest so the lowest matching index has the last word.
  always_comb begin
    o_op     = i_reg_data;
    o_hit    = 1'b0;
    o_hazard = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_sb[k].valid && (i_sb[k].dst == i_src) && (i_src != SRC_NONE)) begin
        if (!i_sb[k].is_load || (k >= LOAD_READY)) begin
          o_op     = i_stage_result[k*DATA_W +: DATA_W];
          o_hit    = 1'b1;
          o_hazard = 1'b0;
        end else begin
          o_op     = i_reg_data;
          o_hit    = 1'b0;
          o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage forwarding and load-use interlock controller with a
// shift-register scoreboard of in-flight register writes.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int               DATA_W      = 16,
  parameter int               REG_AW      = id_hazard_ctrl_pkg::REG_AW,
  parameter int               DEPTH       = 3,
  parameter int               LOAD_READY  = 1,
  parameter logic [REG_AW-1:0] REG_INVALID = id_hazard_ctrl_pkg::REG_INVALID,
  parameter int               CNT_W       = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_id_valid,
  input  logic [REG_AW-1:0]       i_id_src1_addr,
  input  logic [REG_AW-1:0]       i_id_src2_addr,
  input  logic [REG_AW-1:0]       i_id_dst_addr,
  input  logic                    i_id_dst_we,
  input  logic                    i_id_is_load,
  input  logic                    i_flush,
  input  logic [DATA_W-1:0]       i_reg1_data,
  input  logic [DATA_W-1:0]       i_reg2_data,
  input  logic [DEPTH*DATA_W-1:0] i_stage_result,
  output logic [DATA_W-1:0]       o_op1,
  output logic [DATA_W-1:0]       o_op2,
  output logic                    o_fwd1_hit,
  output logic                    o_fwd2_hit,
  output logic                    o_stall,
  output logic                    o_issue,
  output logic [CNT_W-1:0]        o_stall_cnt
);

  // REG_AW must equal the package register width; the entry type uses it.
  sb_entry_t [DEPTH-1:0] r_sb;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic      w_haz1;
  logic      w_haz2;
  sched_e    w_sched;
  rwe_e      w_rwe;
  sb_entry_t w_sb_in;

  id_fwd_select #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .SRC_NONE   (REG_INVALID)
  ) u_fwd1 (
    .i_src          (i_id_src1_addr),
    .i_sb           (r_sb),
    .i_stage_result (i_stage_result),
    .i_reg_data     (i_reg1_data),
    .o_op           (o_op1),
    .o_hit          (o_fwd1_hit),
    .o_hazard       (w_haz1)
  );

  id_fwd_select #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .SRC_NONE   (REG_INVALID)
  ) u_fwd2 (
    .i_src          (i_id_src2_addr),
    .i_sb           (r_sb),
    .i_stage_result (i_stage_result),
    .i_reg_data     (i_reg2_data),
    .o_op           (o_op2),
    .o_hit          (o_fwd2_hit),
    .o_hazard       (w_haz2)
  );

  // Flush outranks the load-use pause; both leave a bubble behind.
  always_comb begin
    w_sched = SCHED_IDLE;
    if (i_id_valid) begin
      if (i_flush)               w_sched = SCHED_KILL;
      else if (w_haz1 || w_haz2) w_sched = SCHED_PAUSE_FOR_LW;
      else                       w_sched = SCHED_ISSUE;
    end
  end

  assign o_stall     = (w_sched == SCHED_PAUSE_FOR_LW);
  assign o_issue     = (w_sched == SCHED_ISSUE);
  assign o_stall_cnt = r_stall_cnt;

  always_comb begin
    w_rwe           = rwe_decode(i_id_dst_we, i_id_is_load);
    w_sb_in.valid   = o_issue && (w_rwe != RWE_NONE) && (i_id_dst_addr != REG_INVALID);
    w_sb_in.dst     = i_id_dst_addr;
    w_sb_in.is_load = (w_rwe == RWE_LOAD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_sb <= {r_sb[DEPTH-2:0], w_sb_in};
      if (o_stall) begin
        if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

endmodule
